// File: rtl/apb_ctrl_pkg.sv
// Shared APB master definitions: bus widths, sequencer states and the latched
// command that is held stable on the bus for a whole transfer.
package apb_ctrl_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [APB_AW-1:0] addr;
    logic [APB_DW-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: searches upward from the requester after the last
// winner and only moves its pointer when the caller consumes the grant.
module apb_rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            pclk,
  input  logic            prset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] last_q, last_d;
  logic          found;
  int            cand;

  // NOTE: every combinational output gets a default before the search so no
  // path through the loop leaves it unassigned, which would infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && found) begin
      last_d = grant_idx;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge pclk or negedge prset) begin
    if (!prset) begin
      last_q <= IW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// APB master shared by NREQ requesters: one transfer at a time, round-robin
// selection, IDLE/SETUP/ACCESS sequencing and a per-transfer ACCESS timeout.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   prset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*APB_AW-1:0] req_addr,
  input  logic [NREQ*APB_DW-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [APB_DW-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [APB_AW-1:0]      paddr,
  output logic [APB_DW-1:0]      pwdata,
  input  logic                   pready,
  input  logic [APB_DW-1:0]      pread,
  input  logic                   perr
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [7:0]  TO_LIMIT = 8'(TIMEOUT);

  apb_state_e        state_q, state_d;
  logic [IW-1:0]     gidx_q, gidx_d;
  apb_cmd_t          cmd_q, cmd_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cnt_inc;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              advance;

  apb_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .pclk      (pclk),
    .prset     (prset),
    .req       (req_valid),
    .advance   (advance),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // The acknowledge is the only combinational output; it is forced low while
  // reset is held so a waiting requester never sees a phantom grant.
  assign req_ack = (state_q == ST_IDLE && prset) ? grant : '0;

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = '0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    advance       = 1'b0;
    cnt_inc       = cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          advance     = 1'b1;
          gidx_d      = grant_idx;
          cmd_d.write = req_write[grant_idx];
          cmd_d.addr  = req_addr[int'(grant_idx)*APB_AW +: APB_AW];
          cmd_d.wdata = req_wdata[int'(grant_idx)*APB_DW +: APB_DW];
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (pready) begin
          state_d             = ST_IDLE;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_err_d           = perr;
          rsp_rdata_d         = (!cmd_q.write && !perr) ? pread : '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIMIT) begin
            state_d             = ST_IDLE;
            psel_d              = 1'b0;
            penable_d           = 1'b0;
            rsp_valid_d[gidx_q] = 1'b1;
            rsp_err_d           = 1'b1;
            rsp_timeout_d       = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prset) begin
    if (!prset) begin
      state_q       <= ST_IDLE;
      gidx_q        <= '0;
      cmd_q         <= '0;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      cmd_q         <= cmd_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // The latched command drives the bus directly, so address, direction and
  // write data stay stable from SETUP through the final ACCESS cycle.
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = cmd_q.write;
  assign paddr       = cmd_q.addr;
  assign pwdata      = cmd_q.wdata;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: directed scenarios plus randomized traffic, all
// compared every cycle against a transaction-level model of the master.
module tb_apb_rr_master;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;

  logic              pclk  = 1'b0;
  logic              prset = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err, rsp_timeout;
  logic              psel, penable, pwrite;
  logic [31:0]       paddr;
  logic [7:0]        pwdata;
  logic              pready;
  logic [7:0]        pread;
  logic              perr;

  always #5 pclk = ~pclk;

  apb_rr_master #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .prset(prset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pread(pread), .perr(perr)
  );

  // ---------------- slave: 16 registers, perr above, configurable stalls
  logic [7:0] sregs [16];
  int         wcnt = 0, wtarget = 0, slave_mode = 1;
  bit         hang = 1'b0;

  assign pready = psel && penable && !hang && (wcnt >= wtarget);
  assign perr   = psel && penable && (paddr >= 32'd16);
  assign pread  = (psel && penable && paddr < 32'd16) ? sregs[paddr[3:0]] : 8'h00;

  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (psel && !penable) begin
      case (slave_mode)
        1:       begin wtarget <= 0; hang <= 1'b0; end
        2:       begin hang <= 1'b1; end
        default: begin wtarget <= int'($urandom_range(0, 2)); hang <= ($urandom_range(0, 9) == 0); end
      endcase
    end
    if (psel && penable && pready && pwrite && !perr) sregs[paddr[3:0]] <= pwdata;
  end

  // ---------------- bookkeeping
  int n_cmp = 0, n_bad = 0, n_rsp = 0;
  logic [NREQ-1:0] ack_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no DUT event within cycle budget at %0t", name, $time);
  endtask

  // ---------------- transaction-level reference model
  logic [7:0]  m_mem [16];
  bit          m_busy = 1'b0;
  int          m_k = 0, m_idx = 0, m_last = NREQ - 1;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [7:0]  m_wdata;
  bit          m_rv = 1'b0, m_rerr, m_rto;
  int          m_ridx = 0;
  logic [7:0]  m_rdata;

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] req);
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge pclk) begin : compare
    logic [NREQ-1:0] e_ack, e_rv;
    bit              e_psel, e_pen;
    int              w;
    ack_seen = req_ack;
    if (!prset) begin
      check("reset req_ack",   32'(req_ack), 0);
      check("reset psel",      32'(psel), 0);
      check("reset penable",   32'(penable), 0);
      check("reset pwrite",    32'(pwrite), 0);
      check("reset paddr",     paddr, 0);
      check("reset pwdata",    32'(pwdata), 0);
      check("reset rsp_valid", 32'(rsp_valid), 0);
      check("reset rsp_rdata", 32'(rsp_rdata), 0);
      check("reset rsp_err",   32'(rsp_err), 0);
      check("reset rsp_to",    32'(rsp_timeout), 0);
      m_busy = 1'b0;
      m_last = NREQ - 1;
      m_rv   = 1'b0;
    end else begin
      e_ack = '0;
      e_rv  = '0;
      w     = -1;
      if (!m_busy) begin
        w = rr_pick(m_last, req_valid);
        if (w >= 0) e_ack[w] = 1'b1;
      end
      if (m_rv) e_rv[m_ridx] = 1'b1;
      e_psel = m_busy && m_k >= 1;
      e_pen  = m_busy && m_k >= 2;
      check("req_ack",   32'(req_ack), 32'(e_ack));
      check("psel",      32'(psel), 32'(e_psel));
      check("penable",   32'(penable), 32'(e_pen));
      check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (e_psel) begin
        check("paddr",  paddr, m_addr);
        check("pwrite", 32'(pwrite), 32'(m_wr));
        check("pwdata", 32'(pwdata), 32'(m_wdata));
      end
      if (m_rv) begin
        n_rsp++;
        check("rsp_rdata",   32'(rsp_rdata), 32'(m_rdata));
        check("rsp_err",     32'(rsp_err), 32'(m_rerr));
        check("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
      end
      // advance to the next cycle
      m_rv = 1'b0;
      if (m_busy) begin
        if (m_k >= 2 && pready) begin
          m_rv = 1'b1; m_ridx = m_idx; m_rerr = perr; m_rto = 1'b0;
          m_rdata = (!m_wr && !perr) ? m_mem[m_addr[3:0]] : 8'h00;
          if (m_wr && !perr) m_mem[m_addr[3:0]] = m_wdata;
          m_busy = 1'b0;
        end else if (m_k >= 2 && (m_k - 1) == TIMEOUT) begin
          m_rv = 1'b1; m_ridx = m_idx; m_rerr = 1'b1; m_rto = 1'b1; m_rdata = 8'h00;
          m_busy = 1'b0;
        end else begin
          m_k++;
        end
      end else if (w >= 0) begin
        m_busy  = 1'b1;
        m_k     = 1;
        m_idx   = w;
        m_last  = w;
        m_wr    = req_write[w];
        m_addr  = req_addr[w*32 +: 32];
        m_wdata = req_wdata[w*8 +: 8];
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [7:0] d);
    req_valid[i]         = 1'b1;
    req_write[i]         = wr;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*8 +: 8]  = d;
  endtask

  task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    set_req(i, wr, a, d);
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge pclk);
      if (req_ack[i]) ok = 1'b1;
      else tick();
    end
    if (!ok) bound_expired("req_ack wait");
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output logic [NREQ-1:0] rv, output logic [7:0] rd,
                          output bit er, output bit to, output bit ps, output int acc);
    bit got = 1'b0;
    cyc = 0; acc = 0; rv = '0; rd = '0; er = 1'b0; to = 1'b0; ps = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge pclk);
      cyc++;
      if (psel && penable) acc++;
      if (rsp_valid != '0) begin
        got = 1'b1; rv = rsp_valid; rd = rsp_rdata; er = rsp_err; to = rsp_timeout; ps = psel;
      end
    end
    if (!got) bound_expired("rsp_valid wait");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc, acc;
    logic [NREQ-1:0] rv;
    logic [7:0]  rd;
    bit          er, to, ps;
    int          g_idx[$], g_cyc[$];

    for (int i = 0; i < 16; i++) begin
      sregs[i] = 8'h00;
      m_mem[i] = 8'h00;
    end
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    slave_mode = 1;

    // write A5 to addr 3 held by requester 0 through reset release
    repeat (3) tick();
    set_req(0, 1'b1, 32'd3, 8'hA5);
    tick();
    prset = 1'b1;
    @(negedge pclk);
    check("first ack after reset", 32'(req_ack), 32'h1);
    tick();
    req_valid[0] = 1'b0;
    @(negedge pclk);
    check("setup psel",    32'(psel), 1);
    check("setup penable", 32'(penable), 0);
    check("setup paddr",   paddr, 32'd3);
    check("setup pwdata",  32'(pwdata), 32'hA5);
    tick();
    @(negedge pclk);
    check("access penable", 32'(penable), 1);
    tick();
    @(negedge pclk);
    check("write rsp_valid", 32'(rsp_valid), 32'h1);
    check("write rsp_err",   32'(rsp_err), 0);

    // read addr 3 back from requester 1
    tick();
    issue(1, 1'b0, 32'd3, 8'h00);
    wait_rsp(cyc, rv, rd, er, to, ps, acc);
    check("read latency",   32'(cyc), 3);
    check("read rsp_valid", 32'(rv), 32'h2);
    check("read rdata",     32'(rd), 32'hA5);

    // both requesters held: strict alternation, one grant every 3 cycles
    tick();
    set_req(0, 1'b1, 32'd0, 8'h11);
    set_req(1, 1'b1, 32'd1, 8'h22);
    for (int c = 0; c < 12; c++) begin
      @(negedge pclk);
      if (req_ack != '0) begin
        g_idx.push_back(req_ack[1] ? 1 : 0);
        g_cyc.push_back(c);
      end
      tick();
    end
    req_valid = '0;
    check("alternation grant count", 32'(g_idx.size()), 4);
    for (int j = 0; j < g_idx.size(); j++) begin
      check("alternation winner", 32'(g_idx[j]), 32'(j % 2));
      check("alternation spacing", 32'(g_cyc[j]), 32'(3 * j));
    end
    repeat (4) tick();

    // out-of-range write: slave error, no timeout, zero data
    issue(0, 1'b1, 32'd20, 8'h5A);
    wait_rsp(cyc, rv, rd, er, to, ps, acc);
    check("perr rsp_valid", 32'(rv), 32'h1);
    check("perr rsp_err",   32'(er), 1);
    check("perr rsp_to",    32'(to), 0);
    check("perr rdata",     32'(rd), 0);

    // stalled slave: exactly TIMEOUT ACCESS cycles then a timeout response
    slave_mode = 2;
    tick();
    issue(1, 1'b0, 32'd5, 8'h00);
    wait_rsp(cyc, rv, rd, er, to, ps, acc);
    check("timeout access cycles", 32'(acc), 32'(TIMEOUT));
    check("timeout rsp_valid",     32'(rv), 32'h2);
    check("timeout rsp_err",       32'(er), 1);
    check("timeout rsp_to",        32'(to), 1);
    check("timeout rdata",         32'(rd), 0);
    check("timeout psel dropped",  32'(ps), 0);

    // reset asserted mid-ACCESS: immediate quiet bus, no response, pointer back to 0
    tick();
    issue(0, 1'b1, 32'd7, 8'h3C);
    @(negedge pclk);
    tick();
    #1;
    prset = 1'b0;
    #1;
    check("async reset psel",      32'(psel), 0);
    check("async reset penable",   32'(penable), 0);
    check("async reset rsp_valid", 32'(rsp_valid), 0);
    slave_mode = 1;
    repeat (2) tick();
    prset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      check("no rsp after reset", 32'(rsp_valid), 0);
      tick();
    end
    set_req(0, 1'b0, 32'd7, 8'h00);
    set_req(1, 1'b0, 32'd3, 8'h00);
    @(negedge pclk);
    check("post-reset first winner", 32'(req_ack), 32'h1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    // randomized traffic with random stalls, timeouts, errors and withdrawals
    slave_mode = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && ack_seen[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)), 8'($urandom_range(0, 255)));
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    tick();
    req_valid = '0;
    repeat (TIMEOUT + 10) tick();
    check("random traffic produced responses", 32'(n_rsp > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
